// File: rtl/priority_req_encoder.sv
// priority_req_encoder: sticky pending register feeding a registered
// valid/ready output that presents one winning request at a time, with
// fixed (highest bit wins) or round-robin (rotating pointer) selection.
module priority_req_encoder #(
  parameter int WIDTH = 16,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req_in,
  input  logic             mode,
  input  logic             enc_ready,
  output logic             enc_valid,
  output logic [IDX_W-1:0] enc_idx,
  output logic [WIDTH-1:0] enc_onehot,
  output logic [WIDTH-1:0] pending,
  output logic             busy,
  output logic             dup_err
);

  logic [WIDTH-1:0] pend_q;
  logic [WIDTH-1:0] pend_next;
  logic [WIDTH-1:0] clr_mask;
  logic [WIDTH-1:0] one_lsb;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] ptr_next;
  logic [IDX_W-1:0] fixed_idx;
  logic [IDX_W-1:0] rr_idx;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] scan_pos;
  int               scan_int;
  logic             any_pend;
  logic             load;
  logic             dup_hit;

  assign one_lsb  = {{(WIDTH-1){1'b0}}, 1'b1};
  assign any_pend = |pend_q;
  assign load     = any_pend && (!enc_valid || enc_ready);
  assign sel_idx  = mode ? rr_idx : fixed_idx;
  assign clr_mask = load ? (one_lsb << sel_idx) : '0;
  // A request on the bit being granted re-sets it, so set wins over clear
  assign pend_next = (pend_q & ~clr_mask) | req_in;
  assign dup_hit   = |(req_in & pend_q & ~clr_mask);
  // Pointer moves one below the winner, wrapping from 0 back to the top bit
  assign ptr_next  = (sel_idx == '0) ? IDX_W'(WIDTH - 1) : sel_idx - 1'b1;
  assign pending   = pend_q;
  assign busy      = any_pend || enc_valid;

  // Fixed priority: the highest set pending bit wins (later iterations override)
  always_comb begin
    fixed_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (pend_q[i]) fixed_idx = IDX_W'(i);
    end
  end

  // Round-robin: walk downward from ptr with wrap; the nearest set bit wins,
  // so the loop runs farthest-first and the closest hit is assigned last
  always_comb begin
    rr_idx   = '0;
    scan_int = 0;
    scan_pos = '0;
    for (int k = WIDTH - 1; k >= 0; k--) begin
      scan_int = int'(ptr) - k;
      if (scan_int < 0) scan_int = scan_int + WIDTH;
      scan_pos = IDX_W'(scan_int);
      if (pend_q[scan_pos]) rr_idx = scan_pos;
    end
  end

  // State update: pending register, output slot, rotating pointer, sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q     <= '0;
      enc_valid  <= 1'b0;
      enc_idx    <= '0;
      enc_onehot <= '0;
      ptr        <= IDX_W'(WIDTH - 1);
      dup_err    <= 1'b0;
    end else begin
      pend_q <= pend_next;
      if (dup_hit) dup_err <= 1'b1;
      if (load) begin
        enc_valid  <= 1'b1;
        enc_idx    <= sel_idx;
        enc_onehot <= one_lsb << sel_idx;
        if (mode) ptr <= ptr_next;
      end else if (enc_valid && enc_ready) begin
        enc_valid  <= 1'b0;
        enc_onehot <= '0;
      end
    end
  end

endmodule

// File: tb/tb_priority_req_encoder.sv
// Directed self-checking bench for priority_req_encoder: a 16-bit instance
// for fixed/round-robin/backpressure cases and a 5-bit instance for the
// non-power-of-two wrap and reset-during-operation cases.
module tb_priority_req_encoder;

  logic clk = 1'b0;

  logic        rst_a   = 1'b1;
  logic        mode_a  = 1'b0;
  logic        ready_a = 1'b1;
  logic [15:0] req_a   = 16'hFFFF;
  logic        valid_a;
  logic [3:0]  idx_a;
  logic [15:0] onehot_a;
  logic [15:0] pending_a;
  logic        busy_a;
  logic        dup_a;

  logic        rst_b   = 1'b1;
  logic        mode_b  = 1'b1;
  logic        ready_b = 1'b1;
  logic [4:0]  req_b   = 5'b11111;
  logic        valid_b;
  logic [2:0]  idx_b;
  logic [4:0]  onehot_b;
  logic [4:0]  pending_b;
  logic        busy_b;
  logic        dup_b;

  int vector_count = 0;
  int miss_count   = 0;

  // Free-running clock shared by both instances
  always #5 clk = ~clk;

  priority_req_encoder #(.WIDTH(16)) dut_a (
    .clk(clk), .rst(rst_a), .req_in(req_a), .mode(mode_a), .enc_ready(ready_a),
    .enc_valid(valid_a), .enc_idx(idx_a), .enc_onehot(onehot_a),
    .pending(pending_a), .busy(busy_a), .dup_err(dup_a)
  );

  priority_req_encoder #(.WIDTH(5)) dut_b (
    .clk(clk), .rst(rst_b), .req_in(req_b), .mode(mode_b), .enc_ready(ready_b),
    .enc_valid(valid_b), .enc_idx(idx_b), .enc_onehot(onehot_b),
    .pending(pending_b), .busy(busy_b), .dup_err(dup_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vector_count++;
    if (observed !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] req, input logic mode,
                               input logic ready);
    req_a   = req;
    mode_a  = mode;
    ready_a = ready;
    tick();
  endtask

  task automatic applyStimulusB(input logic [4:0] req, input logic mode,
                                input logic ready, input logic rst);
    req_b   = req;
    mode_b  = mode;
    ready_b = ready;
    rst_b   = rst;
    tick();
  endtask

  task automatic resetA();
    rst_a = 1'b1;
    req_a = 16'hFFFF;
    tick();
    tick();
    rst_a = 1'b0;
    req_a = 16'h0000;
  endtask

  task automatic checkGrantA(input string tag, input int idx);
    checkOutput({tag, "_valid"}, 32'(valid_a), 32'd1);
    checkOutput({tag, "_idx"}, 32'(idx_a), 32'(idx));
    checkOutput({tag, "_onehot"}, 32'(onehot_a), 32'd1 << idx);
  endtask

  task automatic checkGrantB(input string tag, input int idx, input int ptr_exp);
    checkOutput({tag, "_valid"}, 32'(valid_b), 32'd1);
    checkOutput({tag, "_idx"}, 32'(idx_b), 32'(idx));
    checkOutput({tag, "_onehot"}, 32'(onehot_b), 32'd1 << idx);
    checkOutput({tag, "_ptr"}, 32'(dut_b.ptr), 32'(ptr_exp));
    checkOutput({tag, "_ptr_range"}, 32'(dut_b.ptr < 3'd5), 32'd1);
  endtask

  // Directed test sequence
  initial begin
    int rr_exp[4];
    rr_exp = '{15, 0, 15, 0};

    // Reset held two cycles with all requests high
    tick();
    tick();
    checkOutput("rst_valid", 32'(valid_a), 32'd0);
    checkOutput("rst_idx", 32'(idx_a), 32'd0);
    checkOutput("rst_onehot", 32'(onehot_a), 32'd0);
    checkOutput("rst_pending", 32'(pending_a), 32'd0);
    checkOutput("rst_busy", 32'(busy_a), 32'd0);
    checkOutput("rst_dup", 32'(dup_a), 32'd0);
    checkOutput("rst_ptr", 32'(dut_a.ptr), 32'd15);
    rst_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(16'h0000, 1'b0, 1'b1);
      checkOutput("idle_valid", 32'(valid_a), 32'd0);
      checkOutput("idle_busy", 32'(busy_a), 32'd0);
    end

    // Fixed priority drain of 16'h8421
    applyStimulus(16'h8421, 1'b0, 1'b1);
    checkOutput("fix_latency_valid", 32'(valid_a), 32'd0);
    checkOutput("fix_pending0", 32'(pending_a), 32'h8421);
    applyStimulus(16'h0000, 1'b0, 1'b1);
    checkGrantA("fix_g15", 15);
    checkOutput("fix_pending1", 32'(pending_a), 32'h0421);
    applyStimulus(16'h0000, 1'b0, 1'b1);
    checkGrantA("fix_g10", 10);
    applyStimulus(16'h0000, 1'b0, 1'b1);
    checkGrantA("fix_g5", 5);
    applyStimulus(16'h0000, 1'b0, 1'b1);
    checkGrantA("fix_g0", 0);
    checkOutput("fix_pending4", 32'(pending_a), 32'h0000);
    applyStimulus(16'h0000, 1'b0, 1'b1);
    checkOutput("fix_end_valid", 32'(valid_a), 32'd0);
    checkOutput("fix_end_onehot", 32'(onehot_a), 32'd0);
    checkOutput("fix_end_busy", 32'(busy_a), 32'd0);
    checkOutput("fix_dup", 32'(dup_a), 32'd0);
    checkOutput("fix_ptr_held", 32'(dut_a.ptr), 32'd15);

    // Round-robin fairness with 16'h8001 held
    resetA();
    applyStimulus(16'h8001, 1'b1, 1'b1);
    checkOutput("rr_pending0", 32'(pending_a), 32'h8001);
    checkOutput("rr_dup0", 32'(dup_a), 32'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(16'h8001, 1'b1, 1'b1);
      checkGrantA("rr_grant", rr_exp[i]);
      checkOutput("rr_dup", 32'(dup_a), 32'd1);
    end
    applyStimulus(16'h0000, 1'b1, 1'b1);
    checkOutput("rr_dup_sticky", 32'(dup_a), 32'd1);

    // Backpressure with 16'h0030
    resetA();
    checkOutput("rst_dup_clear", 32'(dup_a), 32'd0);
    applyStimulus(16'h0030, 1'b0, 1'b0);
    checkOutput("bp_pending0", 32'(pending_a), 32'h0030);
    applyStimulus(16'h0000, 1'b0, 1'b0);
    checkGrantA("bp_g5", 5);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(16'h0000, 1'b0, 1'b0);
      checkGrantA("bp_hold", 5);
      checkOutput("bp_hold_pending", 32'(pending_a), 32'h0010);
    end
    applyStimulus(16'h0000, 1'b0, 1'b1);
    checkGrantA("bp_g4", 4);
    checkOutput("bp_pending_end", 32'(pending_a), 32'h0000);
    applyStimulus(16'h0000, 1'b0, 1'b1);
    checkOutput("bp_end_valid", 32'(valid_a), 32'd0);
    checkOutput("bp_end_onehot", 32'(onehot_a), 32'd0);
    checkOutput("bp_idx_held", 32'(idx_a), 32'd4);

    // Set wins over clear on the granted bit
    resetA();
    applyStimulus(16'h0004, 1'b0, 1'b1);
    checkOutput("sw_pending0", 32'(pending_a), 32'h0004);
    applyStimulus(16'h0004, 1'b0, 1'b1);
    checkGrantA("sw_g2a", 2);
    checkOutput("sw_pending1", 32'(pending_a), 32'h0004);
    checkOutput("sw_dup1", 32'(dup_a), 32'd0);
    applyStimulus(16'h0000, 1'b0, 1'b1);
    checkGrantA("sw_g2b", 2);
    checkOutput("sw_pending2", 32'(pending_a), 32'h0000);
    applyStimulus(16'h0000, 1'b0, 1'b1);
    checkOutput("sw_end_valid", 32'(valid_a), 32'd0);
    checkOutput("sw_dup_end", 32'(dup_a), 32'd0);

    // All bits pending, then repeats only raise dup_err
    resetA();
    applyStimulus(16'hFFFF, 1'b0, 1'b0);
    checkOutput("full_pending0", 32'(pending_a), 32'hFFFF);
    checkOutput("full_dup0", 32'(dup_a), 32'd0);
    applyStimulus(16'hFFFF, 1'b0, 1'b0);
    checkGrantA("full_g15", 15);
    checkOutput("full_pending1", 32'(pending_a), 32'hFFFF);
    checkOutput("full_dup1", 32'(dup_a), 32'd1);

    // WIDTH=5 instance: requests during reset are ignored
    checkOutput("b_rst_pending", 32'(pending_b), 32'd0);
    checkOutput("b_rst_ptr", 32'(dut_b.ptr), 32'd4);
    applyStimulusB(5'b10110, 1'b1, 1'b1, 1'b0);
    checkOutput("b_pending0", 32'(pending_b), 32'h16);
    checkOutput("b_latency_valid", 32'(valid_b), 32'd0);
    applyStimulusB(5'b00000, 1'b1, 1'b1, 1'b0);
    checkGrantB("b_g4", 4, 3);
    applyStimulusB(5'b00000, 1'b1, 1'b1, 1'b1);
    checkOutput("b_rst_op_valid", 32'(valid_b), 32'd0);
    checkOutput("b_rst_op_idx", 32'(idx_b), 32'd0);
    checkOutput("b_rst_op_onehot", 32'(onehot_b), 32'd0);
    checkOutput("b_rst_op_pending", 32'(pending_b), 32'd0);
    checkOutput("b_rst_op_busy", 32'(busy_b), 32'd0);
    checkOutput("b_rst_op_ptr", 32'(dut_b.ptr), 32'd4);

    // WIDTH=5 rerun: round-robin order 4, 2, 1
    applyStimulusB(5'b10110, 1'b1, 1'b1, 1'b0);
    applyStimulusB(5'b00000, 1'b1, 1'b1, 1'b0);
    checkGrantB("b_rr4", 4, 3);
    applyStimulusB(5'b00000, 1'b1, 1'b1, 1'b0);
    checkGrantB("b_rr2", 2, 1);
    applyStimulusB(5'b00000, 1'b1, 1'b1, 1'b0);
    checkGrantB("b_rr1", 1, 0);

    // WIDTH=5 wrap: pointer at 0 scans round to bit 4
    applyStimulusB(5'b10010, 1'b1, 1'b1, 1'b0);
    checkOutput("b_wrap_valid0", 32'(valid_b), 32'd0);
    checkOutput("b_wrap_pending", 32'(pending_b), 32'h12);
    applyStimulusB(5'b00000, 1'b1, 1'b1, 1'b0);
    checkGrantB("b_wrap4", 4, 3);
    applyStimulusB(5'b00000, 1'b1, 1'b1, 1'b0);
    checkGrantB("b_wrap1", 1, 0);
    applyStimulusB(5'b00000, 1'b1, 1'b1, 1'b0);
    checkOutput("b_end_valid", 32'(valid_b), 32'd0);
    checkOutput("b_end_dup", 32'(dup_b), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
    $finish;
  end

endmodule
